uart_tx_framer: RTL and testbench
=================================

UART_TX_FRAMER -- requirements
Module: uart_tx_framer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, payload bits per frame (legal 5..9).
REQ-002 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-003 SHALL have parameter STOP_BITS, default 1, stop bits per frame (legal 1 or 2).
REQ-004 SHALL have parameter MSB_FIRST, default 1, payload order: 1 MSB first, 0 LSB first.
REQ-005 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-007 SHALL have port bitClk, input, 1, bit-rate enable; one clk wide per bit period.
REQ-008 SHALL have port in_valid, input, 1, frame request.
REQ-009 SHALL have port in_ready, output, 1, framer can accept a payload.
REQ-010 SHALL have port in, input, DATA_W, payload.
REQ-011 SHALL have port out, output, 1, serial line (idle high).
REQ-012 SHALL have port busy, output, 1, frame armed or in progress.

Function
REQ-013 SHALL implement states IDLE, ARMED, START, DATA, PAR, STOP.
REQ-014 SHALL accept a payload on a clk edge with in_valid=1 and in_ready=1, latching in and entering ARMED; in_ready SHALL be 1 only in IDLE.
REQ-015 SHALL ignore in and in_valid outside IDLE; changes to in after acceptance SHALL NOT affect the frame.
REQ-016 SHALL change state and out only on clk edges where bitClk=1, except acceptance (IDLE->ARMED) and reset.
REQ-017 SHALL ignore a bitClk coinciding with the acceptance edge; ARMED waits for the next bitClk.
REQ-018 SHALL transition on bitClk: ARMED->START (out=0); START->DATA (out=first payload bit); DATA advances one bit per bitClk, after the last bit ->PAR if PARITY!=0 else STOP; PAR->STOP; STOP->IDLE after STOP_BITS bit periods of out=1.
REQ-019 SHALL send bits in[DATA_W-1] down to in[0] when MSB_FIRST=1, and in[0] up to in[DATA_W-1] otherwise.
REQ-020 SHALL drive the parity bit as XOR of all DATA_W payload bits for even parity, and its inverse for odd parity.
REQ-021 SHALL hold every line bit for exactly one bitClk interval; frame length = 1+DATA_W+(PARITY!=0)+STOP_BITS bit periods.
REQ-022 SHALL use a bit counter of $clog2(DATA_W) bits that wraps to 0 on DATA exit.
REQ-023 SHALL drive out=1 in IDLE and ARMED; busy=1 in every state except IDLE.
REQ-024 SHALL, with bitClk tied high, send one bit per clk and insert no gap beyond the IDLE acceptance cycle.
REQ-025 SHALL leave at least one clk of IDLE between frames; back-to-back requests therefore start one bit period later.

Reset
REQ-026 SHALL, on reset=1 at a clk edge, enter IDLE with out=1, in_ready=1, busy=0, counters 0, regardless of state, bitClk or in_valid.
REQ-027 SHALL abort a frame in progress on reset; no partial-frame bits after the reset edge.

Structure
REQ-028 SHALL take parity-mode constants (PAR_NONE, PAR_EVEN, PAR_ODD) and the state encoding from a shared package uart_pkg.
REQ-029 SHALL be one module; the parity reduction is inline, not a sub-module; the optional sub-module uart_bit_tick (clk divider producing bitClk) lives outside this block.

Verification
REQ-030 SHALL check DATA_W=8, PARITY=0, MSB_FIRST=1, in=0xA5, bitClk every 4 clk -> out 0,1,0,1,0,0,1,0,1,1, each held 4 clk, then idle 1.
REQ-031 SHALL check PARITY=1 in=0x07 -> parity bit 1; PARITY=2 in=0x07 -> parity bit 0; STOP_BITS=2 -> two high bit periods before in_ready=1.
REQ-032 SHALL check MSB_FIRST=0 in=0x01 -> data bits 1,0,0,0,0,0,0,0 after start bit.
REQ-033 SHALL check reset asserted during data bit 3 -> next clk out=1, in_ready=1, busy=0; new frame 0xFF then sends correctly.
REQ-034 SHALL check in_valid held high with in changing every clk -> only the value at acceptance is sent; next frame accepted one clk after STOP exit.
REQ-035 SHALL check bitClk tied high, in=0x55 -> 10-clk frame, one bit per clk.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity-mode codes and the transmit framer state encoding.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

endpackage

// File: rtl/uart_tx_framer.sv
// UART transmit framer: serialises one payload per request as start, data, optional parity
// and stop bits, advancing one line bit per bitClk pulse.
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bitClk,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in,
    output logic              out,
    output logic              busy
);

    localparam int              CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    state_t            state_q;
    logic [DATA_W-1:0] data_q;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic              stop_cnt_q;
    logic              out_q;
    logic              busy_q;
    logic              ready_q;
    logic              par_bit;

    // Payload is stored already in line order so data_q[0] is always the first bit sent.
    function automatic logic [DATA_W-1:0] tx_order(input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] r;
        for (int k = 0; k < DATA_W; k++) begin
            r[k] = (MSB_FIRST != 0) ? d[DATA_W-1-k] : d[k];
        end
        return r;
    endfunction

    // Bit order does not change the XOR, so parity is taken from the reordered copy.
    assign par_bit = (^data_q) ^ (PARITY == PAR_ODD);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            out_q      <= 1'b1;
            busy_q     <= 1'b0;
            ready_q    <= 1'b1;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        data_q  <= tx_order(in);
                        state_q <= ARMED;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                    end
                end
                ARMED: begin
                    if (bitClk) begin
                        state_q <= START;
                        out_q   <= 1'b0;
                    end
                end
                START: begin
                    if (bitClk) begin
                        state_q   <= DATA;
                        out_q     <= data_q[0];
                        bit_cnt_q <= '0;
                    end
                end
                DATA: begin
                    if (bitClk) begin
                        if (bit_cnt_q == LAST_BIT) begin
                            bit_cnt_q <= '0;
                            if (PARITY != PAR_NONE) begin
                                state_q <= PAR;
                                out_q   <= par_bit;
                            end else begin
                                state_q    <= STOP;
                                out_q      <= 1'b1;
                                stop_cnt_q <= 1'b0;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                            out_q     <= data_q[bit_cnt_q + CNT_W'(1)];
                        end
                    end
                end
                PAR: begin
                    if (bitClk) begin
                        state_q    <= STOP;
                        out_q      <= 1'b1;
                        stop_cnt_q <= 1'b0;
                    end
                end
                STOP: begin
                    if (bitClk) begin
                        if (STOP_BITS == 1 || stop_cnt_q) begin
                            state_q    <= IDLE;
                            out_q      <= 1'b1;
                            busy_q     <= 1'b0;
                            ready_q    <= 1'b1;
                            stop_cnt_q <= 1'b0;
                        end else begin
                            stop_cnt_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    out_q   <= 1'b1;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign out      = out_q;
    assign busy     = busy_q;
    assign in_ready = ready_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Bench for uart_tx_framer: four parameter variants checked every cycle against a frame-queue model.
module tb_uart_tx_framer;
    import uart_pkg::*;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic       bitClk = 1'b0;
    logic [3:0] vld    = 4'b0;
    logic [7:0] din [4];
    logic [3:0] rdy_w, out_w, busy_w;

    always #5 clk = ~clk;

    uart_tx_framer #(.DATA_W(8), .PARITY(PAR_NONE), .STOP_BITS(1), .MSB_FIRST(1)) u0 (
        .clk(clk), .reset(reset), .bitClk(bitClk), .in_valid(vld[0]), .in_ready(rdy_w[0]),
        .in(din[0]), .out(out_w[0]), .busy(busy_w[0]));
    uart_tx_framer #(.DATA_W(8), .PARITY(PAR_EVEN), .STOP_BITS(2), .MSB_FIRST(1)) u1 (
        .clk(clk), .reset(reset), .bitClk(bitClk), .in_valid(vld[1]), .in_ready(rdy_w[1]),
        .in(din[1]), .out(out_w[1]), .busy(busy_w[1]));
    uart_tx_framer #(.DATA_W(8), .PARITY(PAR_ODD), .STOP_BITS(1), .MSB_FIRST(1)) u2 (
        .clk(clk), .reset(reset), .bitClk(bitClk), .in_valid(vld[2]), .in_ready(rdy_w[2]),
        .in(din[2]), .out(out_w[2]), .busy(busy_w[2]));
    uart_tx_framer #(.DATA_W(8), .PARITY(PAR_NONE), .STOP_BITS(1), .MSB_FIRST(0)) u3 (
        .clk(clk), .reset(reset), .bitClk(bitClk), .in_valid(vld[3]), .in_ready(rdy_w[3]),
        .in(din[3]), .out(out_w[3]), .busy(busy_w[3]));

    int PAR_A  [4] = '{0, 1, 2, 0};
    int STOP_A [4] = '{1, 2, 1, 1};
    int MSB_A  [4] = '{1, 1, 1, 0};

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // bit-period generator: one-clk pulse every bper clocks, tied high when bper is 1
    int bper = 4;
    int bcnt = 0;
    always @(negedge clk) begin
        if (bper <= 1) bitClk = 1'b1;
        else begin
            bcnt   = (bcnt + 1) % bper;
            bitClk = (bcnt == 0);
        end
    end

    // model: a frame is a list of line bits; each bitClk while busy pops the next one
    logic       m_busy [4];
    logic       m_cur  [4];
    logic       mfr    [4][0:15];
    int         mlen   [4];
    int         mpos   [4];

    int         cyc = 0;
    logic       hout [4][0:4095];
    logic       hrdy [4][0:4095];
    logic [7:0] hin  [4][0:4095];

    task automatic model_step(input int i);
        logic [7:0] d;
        int n;
        if (cyc < 4096) hin[i][cyc] = din[i];
        if (reset) begin
            m_busy[i] = 1'b0;
            m_cur[i]  = 1'b1;
        end else if (!m_busy[i]) begin
            if (vld[i]) begin
                d = din[i];
                mfr[i][0] = 1'b0;
                for (int k = 0; k < 8; k++) mfr[i][1+k] = (MSB_A[i] != 0) ? d[7-k] : d[k];
                n = 9;
                if (PAR_A[i] != 0) begin
                    mfr[i][n] = (^d) ^ (PAR_A[i] == 2);
                    n++;
                end
                for (int k = 0; k < STOP_A[i]; k++) begin
                    mfr[i][n] = 1'b1;
                    n++;
                end
                mlen[i]   = n;
                mpos[i]   = 0;
                m_busy[i] = 1'b1;
                m_cur[i]  = 1'b1;
            end
        end else if (bitClk) begin
            if (mpos[i] < mlen[i]) begin
                m_cur[i] = mfr[i][mpos[i]];
                mpos[i]++;
            end else begin
                m_busy[i] = 1'b0;
                m_cur[i]  = 1'b1;
            end
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < 4; i++) model_step(i);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (cyc < 4096) begin
                hout[i][cyc] = out_w[i];
                hrdy[i][cyc] = rdy_w[i];
            end
            chk($sformatf("model_out%0d", i), out_w[i], m_cur[i]);
            chk($sformatf("model_busy%0d", i), busy_w[i], m_busy[i]);
            chk($sformatf("model_rdy%0d", i), rdy_w[i], !m_busy[i]);
        end
    end

    task automatic find_start(input int i, input int s, output int f);
        f = -1;
        for (int c = s; c <= cyc && c < 4096; c++)
            if (f < 0 && hout[i][c] === 1'b0) f = c;
        chk($sformatf("start_found%0d", i), (f >= 0), 1);
        if (f < 0) f = s;
    endtask

    task automatic get_frame(input int i, input int f, input int p, input int n, output logic [15:0] v);
        v = '0;
        for (int k = 0; k < n; k++)
            if (f + k * p < 4096) v = {v[14:0], hout[i][f+k*p]};
    endtask

    task automatic send(input int i, input logic [7:0] val);
        @(negedge clk);
        din[i] = val;
        vld[i] = 1'b1;
        @(negedge clk);
        vld[i] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int s, f, f2;
        logic [15:0] v;
        logic [9:0]  expA;
        for (int i = 0; i < 4; i++) begin
            din[i]    = 8'h00;
            m_busy[i] = 1'b0;
            m_cur[i]  = 1'b1;
            mlen[i]   = 0;
            mpos[i]   = 0;
        end

        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rst_out%0d", i), out_w[i], 1);
            chk($sformatf("rst_rdy%0d", i), rdy_w[i], 1);
            chk($sformatf("rst_busy%0d", i), busy_w[i], 0);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // 0xA5, no parity, bit period 4
        bper = 4;
        s = cyc;
        send(0, 8'hA5);
        repeat (50) @(negedge clk);
        find_start(0, s, f);
        get_frame(0, f, 4, 10, v);
        chk("A5_frame", v[9:0], 10'b0101001011);
        expA = 10'b0101001011;
        for (int k = 0; k < 40; k++)
            chk($sformatf("A5_hold%0d", k), hout[0][f+k], expA[9-k/4]);
        chk("A5_rdy_end", hrdy[0][f+40], 1);
        chk("A5_rdy_stop", hrdy[0][f+39], 0);

        // parity variants, two stop bits, LSB-first, bit period 2
        bper = 2;
        s = cyc;
        @(negedge clk);
        din[1] = 8'h07;
        din[2] = 8'h07;
        din[3] = 8'h01;
        vld[3:1] = 3'b111;
        @(negedge clk);
        vld = 4'b0;
        repeat (40) @(negedge clk);
        find_start(1, s, f);
        get_frame(1, f, 2, 12, v);
        chk("even07_frame", v[11:0], 12'b0_00000111_1_11);
        chk("even07_par", v[2], 1);
        chk("stop2_rdy", hrdy[1][f+24], 1);
        chk("stop2_busy", hrdy[1][f+23], 0);
        find_start(2, s, f);
        get_frame(2, f, 2, 11, v);
        chk("odd07_frame", v[10:0], 11'b0_00000111_0_1);
        chk("odd07_par", v[1], 0);
        find_start(3, s, f);
        get_frame(3, f, 2, 10, v);
        chk("lsb01_frame", v[9:0], 10'b0_10000000_1);

        // reset during data bit 3, then a clean 0xFF frame
        bper = 4;
        send(0, 8'hA5);
        f = -1;
        for (int t = 0; t < 20 && f < 0; t++) begin
            @(negedge clk);
            if (hout[0][cyc] === 1'b0) f = cyc;
        end
        chk("rstD_start", (f >= 0), 1);
        repeat (17) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rstD_out", out_w[0], 1);
        chk("rstD_rdy", rdy_w[0], 1);
        chk("rstD_busy", busy_w[0], 0);
        reset = 1'b0;
        s = cyc;
        send(0, 8'hFF);
        repeat (50) @(negedge clk);
        find_start(0, s, f);
        get_frame(0, f, 4, 10, v);
        chk("FF_frame", v[9:0], 10'b0_11111111_1);

        // in_valid held with in changing every clock
        bper = 2;
        s = cyc;
        @(negedge clk);
        din[0] = 8'h3C;
        vld[0] = 1'b1;
        for (int t = 0; t < 55; t++) begin
            @(negedge clk);
            din[0] = 8'($urandom);
        end
        vld[0] = 1'b0;
        repeat (30) @(negedge clk);
        find_start(0, s, f);
        get_frame(0, f, 2, 10, v);
        chk("hold_frame1", v[9:0], 10'b0_00111100_1);
        chk("hold_idle", hrdy[0][f+20], 1);
        chk("hold_reaccept", hrdy[0][f+21], 0);
        find_start(0, f + 21, f2);
        get_frame(0, f2, 2, 10, v);
        chk("hold_frame2", v[9:0], {1'b0, hin[0][f+21], 1'b1});

        // bitClk tied high
        bper = 1;
        s = cyc;
        send(0, 8'h55);
        repeat (15) @(negedge clk);
        find_start(0, s, f);
        get_frame(0, f, 1, 10, v);
        chk("tied_frame", v[9:0], 10'b0_01010101_1);
        chk("tied_idle", hrdy[0][f+10], 1);
        chk("tied_stop", hrdy[0][f+9], 0);
        chk("tied_armed", hrdy[0][f-1], 0);
        chk("tied_pre_idle", hrdy[0][f-2], 1);

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
